exec_unit_mc: RTL and testbench
===============================

Name: exec_unit_mc

Overview:
- Parametrised multi-cycle execute unit: operand latches A/B/C, barrel shifter, 16-op ARM-style ALU, result latch F and NZCV flag register.
- Generalises the CPU's hard-wired 32-bit execute path to DATA_W bits and adds a valid/ready handshake on both sides, so the controller and a future pipelined front-end can issue operations.
- Sequencing is done by an internal FSM.

Parameters:
- DATA_W, 32, datapath width; power of two, 8..64.
- SHN_W, 8, shift-amount width; amounts of DATA_W or more are legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation.
- op_a  in  DATA_W  first operand (Rn).
- op_b  in  DATA_W  second operand register value (Rm).
- op_c  in  DATA_W  register shift-amount source (Rs); low SHN_W bits used.
- imm  in  DATA_W  immediate second operand (zero-extended by the caller).
- shamt_imm  in  SHN_W  immediate shift amount.
- b_imm_s  in  1  1 = shifter data comes from imm, 0 = from op_b.
- shamt_s  in  1  1 = shift amount is op_c[SHN_W-1:0], 0 = shamt_imm.
- shift_op  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX; others pass through.
- alu_op  in  4  ARM order: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
- set_flags  in  1  update NZCV at completion.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_W  latched F.
- result_wr  out  1  0 for TST/TEQ/CMP/CMN, else 1.
- nzcv  out  4  flag register {N,Z,C,V}.

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1, out_valid=0, result=0, result_wr=0, nzcv=0, all internal latches 0. Reset mid-operation discards the operation with no flag update.
- States: IDLE -> LOAD -> SHIFT -> EXEC -> DONE -> IDLE.
- IDLE: in_ready=1. Accept when in_valid&in_ready; latch all inputs, A<=op_a, B<=op_b, C<=op_c; go to LOAD.
- LOAD: select shifter data and amount; go to SHIFT.
- SHIFT: latch shifter output S and shifter carry sc; go to EXEC.
- EXEC: compute ALU(A,S); F<=result; if set_flags, nzcv<=new flags at this edge; go to DONE.
- DONE: out_valid=1 and held stable until out_ready. Handshake edge returns to IDLE. in_ready=0 in that cycle (no same-cycle re-issue).
- Latency: 4 edges from accept to out_valid high. Minimum initiation interval 5 cycles.
- in_valid is ignored outside IDLE.
- Shifter, amount n:
  - n=0: data passes, sc=C (current nzcv[1]).
  - LSL/LSR with n<DATA_W: standard; sc = last bit shifted out.
  - LSL/LSR with n=DATA_W: result 0; sc = bit0 (LSL) / msb (LSR).
  - LSL/LSR with n>DATA_W: result 0, sc=0.
  - ASR with n>=DATA_W: all bits = msb, sc=msb.
  - ROR: rotate by n mod DATA_W; sc = result msb when n!=0.
  - RRX: ignores n; {C, data[DATA_W-1:1]}, sc=data[0].
- ALU:
  - Arithmetic ops use a DATA_W+1 adder. Subtract carry = NOT borrow. ADC/SBC/RSC use the current C.
  - Arithmetic ops set V = signed overflow.
  - Logical ops: C=sc, V unchanged.
  - N = F msb, Z = (F==0).
  - TST/TEQ/CMP/CMN still drive F (the computed value) with result_wr=0.
- When set_flags=0, nzcv is unchanged.

Optional Feature:
- Macro EXEC_UNIT_SKIP_SHIFT_EN.
- When defined: if the shift amount is 0 (immediate or register) and shift_op is not RRX, LOAD goes directly to EXEC. The ALU uses the unshifted data with sc=C. Latency becomes 3 edges.
- When undefined: always 4 edges. Results and flags are identical in both builds.

Test Plan:
- Reset: drive rst low mid-SHIFT of ADD 5+7 -> out_valid=0, nzcv=0, in_ready=1 immediately; no result ever appears.
- ADD, DATA_W=32: op_a=32'h7FFFFFFF, op_b=1, LSL #0, set_flags -> result 32'h80000000, nzcv=4'b1001, out_valid 4 edges after accept.
- CMP 3,3 then SUBS 0-1:
  - CMP -> result_wr=0, nzcv=4'b0110.
  - SUBS -> result 32'hFFFFFFFF, nzcv=4'b1000.
- Shifter boundaries with MOVS, op_b=32'h80000001:
  - LSR by op_c=32 -> result 0, C=1.
  - LSL 33 -> result 0, C=0.
  - ASR 40 -> 32'hFFFFFFFF, C=1.
  - ROR 33 -> 32'hC0000000, C=1.
  - RRX with C=0 -> 32'h40000000, C=1.
- Backpressure: hold out_ready=0 for 6 cycles -> result/out_valid stable, in_ready=0, in_valid pulses ignored. Release -> one handshake, next accept no earlier than the following cycle.
- DATA_W=16, ADC 16'hFFFF+0 with C=1 -> result 0, nzcv=4'b0110. Repeat with EXEC_UNIT_SKIP_SHIFT_EN defined -> same values, out_valid after 3 edges.

Source files
------------

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle execute unit with operand latches A/B/C, a barrel
// shifter, a 16-op ARM-order ALU, result latch F and an NZCV flag register.
// The unit has a valid/ready handshake on the issue side and on the result side.
// Optional build macro EXEC_UNIT_SKIP_SHIFT_EN: a zero shift amount (other than
// RRX) bypasses the SHIFT state, so latency drops from 4 to 3 edges.
module exec_unit_mc #(
  parameter int DATA_W = 32,
  parameter int SHN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_c,
  input  logic [DATA_W-1:0] imm,
  input  logic [SHN_W-1:0]  shamt_imm,
  input  logic              b_imm_s,
  input  logic              shamt_s,
  input  logic [2:0]        shift_op,
  input  logic [3:0]        alu_op,
  input  logic              set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_wr,
  output logic [3:0]        nzcv
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   a_r, b_r, c_r, imm_r;
  logic [SHN_W-1:0]    shamt_imm_r;
  logic                b_imm_sel_r, shamt_sel_r, set_flags_r;
  logic [2:0]          shift_op_r;
  logic [3:0]          alu_op_r;
  logic [DATA_W-1:0]   d_r, s_r;
  logic [SHN_W-1:0]    n_r;
  logic                sc_r;

  logic [DATA_W-1:0]   sel_data_s;
  logic [SHN_W-1:0]    sel_amt_s;
  logic [DATA_W:0]     shift_out_s;
  logic [DATA_W+4:0]   alu_out_s;
  logic                unused_c_s;

  // Barrel shifter: returns {carry_out, shifted_data}.
  function automatic logic [DATA_W:0] shift_f(input logic [DATA_W-1:0] d,
                                              input logic [SHN_W-1:0]  n,
                                              input logic [2:0]        op,
                                              input logic              cin);
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] t;
    logic              c;
    int unsigned       ni;
    int unsigned       k;
    ni = 32'(n);
    r  = d;
    c  = cin;
    t  = {DATA_W{1'b0}};
    k  = 32'd0;
    case (op)
      3'd0: begin
        if (ni == 32'd0) begin
          r = d;
        end else if (ni < DATA_W) begin
          r = d << ni;
          t = d >> (DATA_W - ni);
          c = t[0];
        end else if (ni == DATA_W) begin
          r = {DATA_W{1'b0}};
          c = d[0];
        end else begin
          r = {DATA_W{1'b0}};
          c = 1'b0;
        end
      end
      3'd1: begin
        if (ni == 32'd0) begin
          r = d;
        end else if (ni < DATA_W) begin
          r = d >> ni;
          t = d >> (ni - 32'd1);
          c = t[0];
        end else if (ni == DATA_W) begin
          r = {DATA_W{1'b0}};
          c = d[DATA_W-1];
        end else begin
          r = {DATA_W{1'b0}};
          c = 1'b0;
        end
      end
      3'd2: begin
        if (ni == 32'd0) begin
          r = d;
        end else if (ni < DATA_W) begin
          r = $signed(d) >>> ni;
          t = d >> (ni - 32'd1);
          c = t[0];
        end else begin
          r = {DATA_W{d[DATA_W-1]}};
          c = d[DATA_W-1];
        end
      end
      3'd3: begin
        if (ni == 32'd0) begin
          r = d;
        end else begin
          // Rotating by a multiple of DATA_W leaves data unchanged; the
          // left shift by DATA_W yields zero, so the OR stays correct.
          k = ni % DATA_W;
          r = (d >> k) | (d << (DATA_W - k));
          c = r[DATA_W-1];
        end
      end
      3'd4: begin
        r = {cin, d[DATA_W-1:1]};
        c = d[0];
      end
      default: begin
        r = d;
        c = cin;
      end
    endcase
    return {c, r};
  endfunction

  // ALU: returns {N, Z, C, V, write_enable, F}.
  function automatic logic [DATA_W+4:0] alu_f(input logic [3:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] s,
                                              input logic              sc,
                                              input logic [3:0]        fl);
    logic [DATA_W-1:0] x, y, res;
    logic [DATA_W:0]   sum;
    logic              cin, arith, c, v;
    x     = a;
    y     = s;
    cin   = 1'b0;
    arith = 1'b1;
    res   = {DATA_W{1'b0}};
    case (op)
      4'd0, 4'd8:  begin arith = 1'b0; res = a & s; end
      4'd1, 4'd9:  begin arith = 1'b0; res = a ^ s; end
      4'd2, 4'd10: begin y = ~s; cin = 1'b1; end
      4'd3:        begin x = s; y = ~a; cin = 1'b1; end
      4'd4, 4'd11: begin cin = 1'b0; end
      4'd5:        begin cin = fl[1]; end
      4'd6:        begin y = ~s; cin = fl[1]; end
      4'd7:        begin x = s; y = ~a; cin = fl[1]; end
      4'd12:       begin arith = 1'b0; res = a | s; end
      4'd13:       begin arith = 1'b0; res = s; end
      4'd14:       begin arith = 1'b0; res = a & ~s; end
      default:     begin arith = 1'b0; res = ~s; end
    endcase
    // Subtraction is a + ~b + 1, so the adder carry is already NOT borrow.
    sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
    if (arith) begin
      res = sum[DATA_W-1:0];
      c   = sum[DATA_W];
      v   = (x[DATA_W-1] == y[DATA_W-1]) && (res[DATA_W-1] != x[DATA_W-1]);
    end else begin
      c = sc;
      v = fl[0];
    end
    return {res[DATA_W-1], (res == {DATA_W{1'b0}}), c, v, (op[3:2] != 2'b10), res};
  endfunction

  assign sel_data_s  = b_imm_sel_r ? imm_r : b_r;
  assign sel_amt_s   = shamt_sel_r ? c_r[SHN_W-1:0] : shamt_imm_r;
  assign shift_out_s = shift_f(d_r, n_r, shift_op_r, nzcv[1]);
  assign alu_out_s   = alu_f(alu_op_r, a_r, s_r, sc_r, nzcv);
  // Only the low SHN_W bits of the C latch feed the shifter.
  assign unused_c_s  = ^c_r;

  // Sequencing FSM with all latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= {DATA_W{1'b0}};
      result_wr   <= 1'b0;
      nzcv        <= 4'd0;
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      c_r         <= {DATA_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
      shamt_imm_r <= {SHN_W{1'b0}};
      b_imm_sel_r <= 1'b0;
      shamt_sel_r <= 1'b0;
      set_flags_r <= 1'b0;
      shift_op_r  <= 3'd0;
      alu_op_r    <= 4'd0;
      d_r         <= {DATA_W{1'b0}};
      n_r         <= {SHN_W{1'b0}};
      s_r         <= {DATA_W{1'b0}};
      sc_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r         <= op_a;
            b_r         <= op_b;
            c_r         <= op_c;
            imm_r       <= imm;
            shamt_imm_r <= shamt_imm;
            b_imm_sel_r <= b_imm_s;
            shamt_sel_r <= shamt_s;
            set_flags_r <= set_flags;
            shift_op_r  <= shift_op;
            alu_op_r    <= alu_op;
            in_ready    <= 1'b0;
            state_r     <= LOAD;
          end else begin
            in_ready    <= 1'b1;
          end
        end
        LOAD: begin
          d_r <= sel_data_s;
          n_r <= sel_amt_s;
`ifdef EXEC_UNIT_SKIP_SHIFT_EN
          if ((sel_amt_s == {SHN_W{1'b0}}) && (shift_op_r != 3'd4)) begin
            s_r     <= sel_data_s;
            sc_r    <= nzcv[1];
            state_r <= EXEC;
          end else begin
            state_r <= SHIFT;
          end
`else
          state_r <= SHIFT;
`endif
        end
        SHIFT: begin
          s_r     <= shift_out_s[DATA_W-1:0];
          sc_r    <= shift_out_s[DATA_W];
          state_r <= EXEC;
        end
        EXEC: begin
          result    <= alu_out_s[DATA_W-1:0];
          result_wr <= alu_out_s[DATA_W];
          if (set_flags_r) begin
            nzcv <= alu_out_s[DATA_W+4:DATA_W+1];
          end else begin
            nzcv <= nzcv;
          end
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Testbench for exec_unit_mc: a 32-bit instance checked every cycle against an
// arithmetic reference model (directed cases pin the model with literal values,
// then randomized operations), plus a 16-bit instance with directed ADC checks.
module tb_exec_unit_mc;
  localparam int W  = 32;
  localparam int SN = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, result_wr;
  logic [W-1:0]  op_a, op_b, op_c, imm, result;
  logic [SN-1:0] shamt_imm;
  logic          b_imm_s, shamt_s, set_flags;
  logic [2:0]    shift_op;
  logic [3:0]    alu_op, nzcv;

  logic          v16, rdy16, ov16, ordy16, wr16, bsel16, nsel16, sf16;
  logic [15:0]   a16, b16, c16, imm16, res16;
  logic [SN-1:0] sh16;
  logic [2:0]    sop16;
  logic [3:0]    aop16, nzcv16;

  exec_unit_mc #(.DATA_W(W), .SHN_W(SN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .imm(imm), .shamt_imm(shamt_imm),
    .b_imm_s(b_imm_s), .shamt_s(shamt_s), .shift_op(shift_op), .alu_op(alu_op),
    .set_flags(set_flags), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_wr(result_wr), .nzcv(nzcv));

  exec_unit_mc #(.DATA_W(16), .SHN_W(SN)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .op_a(a16), .op_b(b16), .op_c(c16), .imm(imm16), .shamt_imm(sh16),
    .b_imm_s(bsel16), .shamt_s(nsel16), .shift_op(sop16), .alu_op(aop16),
    .set_flags(sf16), .out_valid(ov16), .out_ready(ordy16),
    .result(res16), .result_wr(wr16), .nzcv(nzcv16));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bt(input logic [63:0] d, input int idx);
    return ((d >> idx) & 64'd1) != 64'd0;
  endfunction

  // Shifter reference built bit by bit from the rules.
  function automatic void m_shift(input logic [63:0] d, input int w, input int n,
                                  input int op, input bit cin,
                                  output logic [63:0] r, output bit c);
    int k;
    r = 64'd0;
    c = cin;
    if (op == 4) begin
      for (int i = 0; i < w - 1; i++) r |= {63'd0, bt(d, i + 1)} << i;
      r |= {63'd0, cin} << (w - 1);
      c = bt(d, 0);
    end else if (op > 4 || n == 0) begin
      r = d;
    end else if (op == 0) begin
      for (int i = 0; i < w; i++) if (i >= n) r |= {63'd0, bt(d, i - n)} << i;
      c = (n <= w) ? bt(d, w - n) : 1'b0;
    end else if (op == 1) begin
      for (int i = 0; i < w; i++) if (i + n < w) r |= {63'd0, bt(d, i + n)} << i;
      c = (n <= w) ? bt(d, n - 1) : 1'b0;
    end else if (op == 2) begin
      for (int i = 0; i < w; i++)
        r |= {63'd0, ((i + n < w) ? bt(d, i + n) : bt(d, w - 1))} << i;
      c = (n <= w) ? bt(d, n - 1) : bt(d, w - 1);
    end else begin
      k = n % w;
      for (int i = 0; i < w; i++) r |= {63'd0, bt(d, (i + k) % w)} << i;
      c = bt(r, w - 1);
    end
  endfunction

  // ALU reference using exact integer arithmetic.
  function automatic void m_alu(input int op, input logic [63:0] a, input logic [63:0] s,
                                input bit sc, input logic [3:0] fin, input int w,
                                output logic [63:0] res, output bit wr, output logic [3:0] nz);
    longint ua, us, sa, ss, ur, sr, m, bw;
    bit arith, c, v, cin;
    m  = longint'(1) << w;
    ua = longint'(a);
    us = longint'(s);
    sa = (ua >= m / 2) ? ua - m : ua;
    ss = (us >= m / 2) ? us - m : us;
    cin = fin[1];
    bw = cin ? 0 : 1;
    arith = 1'b1; ur = 0; sr = 0; c = 1'b0; res = 64'd0;
    case (op)
      0, 8:   begin arith = 1'b0; res = a & s; end
      1, 9:   begin arith = 1'b0; res = a ^ s; end
      2, 10:  begin ur = ua - us; sr = sa - ss; c = (ua >= us); end
      3:      begin ur = us - ua; sr = ss - sa; c = (us >= ua); end
      4, 11:  begin ur = ua + us; sr = sa + ss; c = (ur >= m); end
      5:      begin ur = ua + us + longint'(cin); sr = sa + ss + longint'(cin); c = (ur >= m); end
      6:      begin ur = ua - us - bw; sr = sa - ss - bw; c = (ua >= us + bw); end
      7:      begin ur = us - ua - bw; sr = ss - sa - bw; c = (us >= ua + bw); end
      12:     begin arith = 1'b0; res = a | s; end
      13:     begin arith = 1'b0; res = s; end
      14:     begin arith = 1'b0; res = a & ~s; end
      default: begin arith = 1'b0; res = ~s; end
    endcase
    res = arith ? (64'(ur) & 64'(m - 1)) : (res & 64'(m - 1));
    if (arith) v = (sr > m / 2 - 1) || (sr < -(m / 2));
    else begin c = sc; v = fin[0]; end
    nz = {bt(res, w - 1), res == 64'd0, c, v};
    wr = !(op >= 8 && op <= 11);
  endfunction

  function automatic int exp_lat(input int n, input int sop);
`ifdef EXEC_UNIT_SKIP_SHIFT_EN
    return (n == 0 && sop != 4) ? 3 : 4;
`else
    return 4;
`endif
  endfunction

  // Reference model state for the 32-bit instance.
  bit            m_idle = 1'b1, m_done = 1'b0, m_wr = 1'b0, p_wr;
  int            m_cnt = 0;
  logic [31:0]   m_res = 32'd0, p_res;
  logic [3:0]    m_nzcv = 4'd0, p_nzcv;

  // Compare process: every falling edge compare DUT against model, then advance model.
  initial begin
    logic [63:0] sr, fr;
    bit sc, wr;
    logic [3:0] nz;
    int n;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_idle = 1'b1; m_done = 1'b0; m_cnt = 0; m_res = 32'd0; m_wr = 1'b0; m_nzcv = 4'd0;
      end
      chk("in_ready", 64'(in_ready), 64'(m_idle));
      chk("out_valid", 64'(out_valid), 64'(m_done));
      chk("result", 64'(result), 64'(m_res));
      chk("result_wr", 64'(result_wr), 64'(m_wr));
      chk("nzcv", 64'(nzcv), 64'(m_nzcv));
      if (rst) begin
        if (m_idle) begin
          if (in_valid) begin
            n = shamt_s ? int'(op_c[SN-1:0]) : int'(shamt_imm);
            m_shift(64'(b_imm_s ? imm : op_b), W, n, int'(shift_op), m_nzcv[1], sr, sc);
            m_alu(int'(alu_op), 64'(op_a), sr, sc, m_nzcv, W, fr, wr, nz);
            p_res  = fr[31:0];
            p_wr   = wr;
            p_nzcv = set_flags ? nz : m_nzcv;
            m_cnt  = exp_lat(n, int'(shift_op)) - 1;
            m_idle = 1'b0;
          end
        end else if (!m_done) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_done = 1'b1; m_res = p_res; m_wr = p_wr; m_nzcv = p_nzcv;
          end
        end else if (out_ready) begin
          m_done = 1'b0;
          m_idle = 1'b1;
        end
      end
    end
  end

  // Issue one operation to the 32-bit unit; optional literal checks.
  task automatic run_op(input int aop, input int sop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] im, input logic [7:0] sh,
                        input bit bsel, input bit nsel, input bit sf, input int hold,
                        input bit lit, input logic [31:0] eres, input logic [3:0] enz, input bit ewr);
    int t, edges, n;
    alu_op = 4'(aop); shift_op = 3'(sop); op_a = a; op_b = b; op_c = c; imm = im;
    shamt_imm = sh; b_imm_s = bsel; shamt_s = nsel; set_flags = sf;
    in_valid = 1'b1; out_ready = 1'b0;
    n = nsel ? int'(c[SN-1:0]) : int'(sh);
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin @(posedge clk); #1; edges++; end
    chk("done_wait", 64'(out_valid), 64'd1);
    if (lit) begin
      chk("lit_latency", 64'(edges), 64'(exp_lat(n, sop)));
      chk("lit_result", 64'(result), 64'(eres));
      chk("lit_nzcv", 64'(nzcv), 64'(enz));
      chk("lit_wr", 64'(result_wr), 64'(ewr));
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a = $urandom; alu_op = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      if (lit) begin
        chk("bp_result", 64'(result), 64'(eres));
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Issue one flag-setting, unshifted operation to the 16-bit unit.
  task automatic run16(input int aop, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eres, input logic [3:0] enz);
    int t, edges;
    aop16 = 4'(aop); a16 = a; b16 = b; v16 = 1'b1; ordy16 = 1'b0;
    t = 0;
    while (!rdy16 && t < 20) begin @(posedge clk); #1; t++; end
    chk("w16_accept", 64'(rdy16), 64'd1);
    @(posedge clk); #1;
    v16 = 1'b0;
    edges = 1;
    while (!ov16 && edges < 20) begin @(posedge clk); #1; edges++; end
    chk("w16_latency", 64'(edges), 64'(exp_lat(0, 0)));
    chk("w16_result", 64'(res16), 64'(eres));
    chk("w16_nzcv", 64'(nzcv16), 64'(enz));
    ordy16 = 1'b1;
    @(posedge clk); #1;
    ordy16 = 1'b0;
  endtask

  initial begin
    int pick, amt;
    logic [31:0] specials [5];
    specials[0] = 32'h0; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h7FFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h1;
    in_valid = 1'b0; out_ready = 1'b0; op_a = 32'd0; op_b = 32'd0; op_c = 32'd0;
    imm = 32'd0; shamt_imm = 8'd0; b_imm_s = 1'b0; shamt_s = 1'b0; shift_op = 3'd0;
    alu_op = 4'd0; set_flags = 1'b0;
    v16 = 1'b0; ordy16 = 1'b0; a16 = 16'd0; b16 = 16'd0; c16 = 16'd0; imm16 = 16'd0;
    sh16 = 8'd0; bsel16 = 1'b0; nsel16 = 1'b0; sop16 = 3'd0; aop16 = 4'd0; sf16 = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_nzcv", 64'(nzcv), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ADD overflow, CMP equal, SUBS with backpressure
    run_op(4, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 8'd0, 0, 0, 1, 0, 1, 32'h80000000, 4'b1001, 1);
    run_op(10, 0, 32'd3, 32'd3, 0, 0, 8'd0, 0, 0, 1, 0, 1, 32'h0, 4'b0110, 0);
    run_op(2, 0, 32'd0, 32'd1, 0, 0, 8'd0, 0, 0, 1, 6, 1, 32'hFFFFFFFF, 4'b1000, 1);

    // Reset while ADD 5+7 sits in SHIFT
    alu_op = 4'd4; shift_op = 3'd0; op_a = 32'd5; op_b = 32'd7; shamt_imm = 8'd0;
    b_imm_s = 1'b0; shamt_s = 1'b0; set_flags = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_nzcv", 64'(nzcv), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("midrst_no_result", 64'(out_valid), 64'd0);

    // Shifter boundaries with MOVS, op_b = 32'h80000001
    run_op(13, 1, 0, 32'h80000001, 32'd32, 0, 8'd0, 0, 1, 1, 0, 1, 32'h0, 4'b0110, 1);
    run_op(13, 0, 0, 32'h80000001, 0, 0, 8'd33, 0, 0, 1, 0, 1, 32'h0, 4'b0100, 1);
    run_op(13, 2, 0, 32'h80000001, 0, 0, 8'd40, 0, 0, 1, 0, 1, 32'hFFFFFFFF, 4'b1010, 1);
    run_op(13, 3, 0, 32'h80000001, 0, 0, 8'd33, 0, 0, 1, 0, 1, 32'hC0000000, 4'b1010, 1);
    run_op(4, 0, 32'd1, 32'd1, 0, 0, 8'd0, 0, 0, 1, 0, 1, 32'h2, 4'b0000, 1);
    run_op(13, 4, 0, 32'h80000001, 0, 0, 8'd5, 0, 0, 1, 0, 1, 32'h40000000, 4'b0010, 1);

    // Randomized operations, checked by the compare process
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: amt = 0;
        1: amt = 1;
        2: amt = 31;
        3: amt = 32;
        4: amt = 33;
        5: amt = $urandom_range(0, 255);
        default: amt = $urandom_range(2, 30);
      endcase
      run_op($urandom_range(0, 15), $urandom_range(0, 7),
             ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 4)] : $urandom,
             ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 4)] : $urandom,
             ($urandom & 32'hFFFFFF00) | 32'(amt), $urandom, 8'(amt),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 0, 32'h0, 4'h0, 0);
    end

    // 16-bit instance: set C via CMP 0,0 then ADC 16'hFFFF + 0 + C
    run16(10, 16'h0000, 16'h0000, 16'h0000, 4'b0110);
    run16(5, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
